// File: rtl/mem_byte_sequencer_pkg.sv
// Shared encodings for the byte-serial memory sequencer: access sizes,
// FSM states, byte counts and the alignment rule.
package mem_byte_sequencer_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [2:0] BYTES_BYTE = 3'd1;
  localparam logic [2:0] BYTES_HALF = 3'd2;
  localparam logic [2:0] BYTES_WORD = 3'd4;

  function automatic logic [2:0] byte_count(input size_e size);
    case (size)
      SZ_BYTE: byte_count = BYTES_BYTE;
      SZ_HALF: byte_count = BYTES_HALF;
      default: byte_count = BYTES_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lsb);
    case (size)
      SZ_HALF: misaligned = addr_lsb[0];
      SZ_WORD: misaligned = (addr_lsb != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// Control-unit request/response bus plus the byte-wide RAM port.
interface mem_byte_sequencer_if;
  logic        mov;
  logic        read_write;
  logic [2:0]  ms;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        align_err;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  modport slave (
    input  mov, read_write, ms, address, data_in, mem_rdata,
    output data_out, moc, align_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output mov, read_write, ms, address, data_in, mem_rdata,
    input  data_out, moc, align_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_byte_sequencer_load_extend.sv
// Zero/sign extension of an assembled load value (right-justified in raw).
module mem_load_extend
  import mem_byte_sequencer_pkg::*;
(
  input  logic [31:0] raw,
  input  size_e       size,
  input  logic        sgn,
  output logic [31:0] result
);

  always_comb begin
    case (size)
      SZ_BYTE: result = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_HALF: result = {{16{sgn & raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Sequences 8/16/32-bit loads and stores as big-endian byte transfers
// against a 256x8 RAM with a combinational read port.
//
// state   | meaning
// IDLE    | waiting for mov; request fields latched on the accepting edge
// XFER    | one RAM byte per cycle, index 0..N-1
// DONE    | moc (and align_err) held until mov drops
module mem_byte_sequencer
  import mem_byte_sequencer_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  mem_byte_sequencer_if.slave  bus
);

  state_e      state_q, state_d;
  logic        rw_q;
  size_e       size_q;
  logic        sgn_q;
  logic [7:0]  base_q;
  logic [31:0] data_q;
  logic [2:0]  n_q;
  logic [1:0]  idx_q;
  logic [31:0] asm_q;
  logic        err_q;
  logic [31:0] data_out_q;

  size_e       size_in;
  logic        mis_in;
  logic        xfer;
  logic        last;
  logic [1:0]  sh;
  logic [31:0] asm_next;
  logic [31:0] ext;
  logic        unused_bits;

  assign unused_bits = ^{bus.address[31:8], asm_q[31:24]};

  assign size_in  = bus.ms[1] ? SZ_WORD : (bus.ms[0] ? SZ_HALF : SZ_BYTE);
  assign mis_in   = misaligned(size_in, bus.address[1:0]);
  assign xfer     = (state_q == ST_XFER);
  assign last     = ({1'b0, idx_q} == (n_q - 3'd1));
  assign asm_next = {asm_q[23:0], bus.mem_rdata};
  // Most significant byte goes out first: byte k sits (N-1-k) bytes up.
  assign sh       = 2'(n_q - 3'd1 - {1'b0, idx_q});

  mem_load_extend u_extend (
    .raw    (asm_next),
    .size   (size_q),
    .sgn    (sgn_q),
    .result (ext)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.mov) state_d = mis_in ? ST_DONE : ST_XFER;
      ST_XFER: if (last) state_d = ST_DONE;
      ST_DONE: if (!bus.mov) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 8'h00;
    bus.mem_we    = 1'b0;
    if (xfer) begin
      bus.mem_addr = base_q + {6'b000000, idx_q};
      if (!rw_q) begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = data_q[{sh, 3'b000} +: 8];
      end
    end
    bus.moc       = (state_q == ST_DONE);
    bus.align_err = (state_q == ST_DONE) & err_q;
    bus.data_out  = data_out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rw_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      sgn_q      <= 1'b0;
      base_q     <= 8'h00;
      data_q     <= 32'h0;
      n_q        <= 3'd0;
      idx_q      <= 2'd0;
      asm_q      <= 32'h0;
      err_q      <= 1'b0;
      data_out_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.mov) begin
            rw_q   <= bus.read_write;
            size_q <= size_in;
            sgn_q  <= bus.ms[2];
            base_q <= bus.address[7:0];
            data_q <= bus.data_in;
            n_q    <= byte_count(size_in);
            idx_q  <= 2'd0;
            asm_q  <= 32'h0;
            err_q  <= mis_in;
          end
        end
        ST_XFER: begin
          idx_q <= idx_q + 2'd1;
          if (rw_q) begin
            asm_q <= asm_next;
            if (last) data_out_q <= ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
